// File: rtl/mb_slice_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mb_slice_pkg
//  Brief    : Shared types and helpers for the MB data-path slice.
//  Revision : 1.0  initial release
// ============================================================================
package mb_slice_pkg;

   localparam int PAR_GRP = 6;

   // MB register source select
   typedef enum logic [2:0] {
      MB_SRC_AR      = 3'd0,
      MB_SRC_CACHE   = 3'd1,
      MB_SRC_MEM     = 3'd2,
      MB_SRC_CHB     = 3'd3,
      MB_SRC_CCW_MIX = 3'd4,
      MB_SRC_CBUS    = 3'd5,
      MB_SRC_WORD    = 3'd6,
      MB_SRC_HOLD    = 3'd7
   } mb_src_e;

   // mem_to_cache source select
   typedef enum logic [1:0] {
      M2C_SRC_MEM  = 2'd0,
      M2C_SRC_MB   = 2'd1,
      M2C_SRC_AR   = 2'd2,
      M2C_SRC_CBUS = 2'd3
   } m2c_src_e;

   // Odd parity bit for one 6-bit group: 1 when the group has an even count of ones
   function automatic logic odd_par6(input logic [PAR_GRP-1:0] d);
      return ~^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mb_slice_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : mb_slice_gen_if
//  Brief    : Bus bundle of the MB slice; master drives controls/data,
//             slave is the slice itself. MB_CHB_PAR_EN adds chb_par_err_h.
//  Revision : 1.0  initial release
// ============================================================================
interface mb_slice_gen_if #(
   parameter int SLICE_W = 12,
   parameter int WORDS   = 4,
   parameter int CHB_AW  = 7,
   parameter int CCW_AW  = 4
);
   localparam int WSEL_W = $clog2(WORDS);
   localparam int NGRP   = SLICE_W / 6;

   logic [SLICE_W-1:0] ar_h;
   logic [SLICE_W-1:0] cache_data_h;
   logic [SLICE_W-1:0] mem_data_in_h;
   logic [SLICE_W-1:0] ccw_buf_in_h;
   logic [SLICE_W-1:0] cbus_re_h;
   logic [2:0]         mb_in_sel_h;
   logic               mb_sel_hold_h;
   logic [WSEL_W-1:0]  mb_word_sel_h;
   logic               mem_data_ld_h;
   logic [WORDS-1:0]   mb_hold_in_h;
   logic               chb_adr_ld_h;
   logic [CHB_AW-1:0]  chb_adr_in_h;
   logic               chb_step_h;
   logic               ch_reverse_h;
   logic               chb_wr_h;
   logic               ccw_buf_wr_h;
   logic [CCW_AW-1:0]  ccw_buf_adr_h;
   logic               ccl_mix_mb_sel_h;
   logic               mem_to_c_en_h;
   logic [1:0]         mem_to_c_sel_h;
   logic               cbus_out_hold_h;

   logic [SLICE_W-1:0] mb_h;
   logic [NGRP-1:0]    mb_par_odd_h;
   logic [SLICE_W-1:0] ccw_mix_h;
   logic [SLICE_W-1:0] mem_to_cache_h;
   logic [SLICE_W-1:0] pt_in_h;
   logic [SLICE_W-1:0] cbus_te_h;
   logic [CHB_AW-1:0]  chb_adr_h;
`ifdef MB_CHB_PAR_EN
   logic               chb_par_err_h;
`endif

   modport master (
      output ar_h, cache_data_h, mem_data_in_h, ccw_buf_in_h, cbus_re_h,
      output mb_in_sel_h, mb_sel_hold_h, mb_word_sel_h, mem_data_ld_h, mb_hold_in_h,
      output chb_adr_ld_h, chb_adr_in_h, chb_step_h, ch_reverse_h, chb_wr_h,
      output ccw_buf_wr_h, ccw_buf_adr_h, ccl_mix_mb_sel_h,
      output mem_to_c_en_h, mem_to_c_sel_h, cbus_out_hold_h,
      input  mb_h, mb_par_odd_h, ccw_mix_h, mem_to_cache_h, pt_in_h,
      input  cbus_te_h, chb_adr_h
`ifdef MB_CHB_PAR_EN
      , input chb_par_err_h
`endif
   );

   modport slave (
      input  ar_h, cache_data_h, mem_data_in_h, ccw_buf_in_h, cbus_re_h,
      input  mb_in_sel_h, mb_sel_hold_h, mb_word_sel_h, mem_data_ld_h, mb_hold_in_h,
      input  chb_adr_ld_h, chb_adr_in_h, chb_step_h, ch_reverse_h, chb_wr_h,
      input  ccw_buf_wr_h, ccw_buf_adr_h, ccl_mix_mb_sel_h,
      input  mem_to_c_en_h, mem_to_c_sel_h, cbus_out_hold_h,
      output mb_h, mb_par_odd_h, ccw_mix_h, mem_to_cache_h, pt_in_h,
      output cbus_te_h, chb_adr_h
`ifdef MB_CHB_PAR_EN
      , output chb_par_err_h
`endif
   );

endinterface
`default_nettype wire

// File: rtl/mb_slice_gen_chbuf.sv
`default_nettype none
// ============================================================================
//  Module   : mb_chbuf
//  Brief    : Channel buffer: auto-stepping address counter, RAM and
//             registered read port. MB_CHB_PAR_EN stores per-group parity
//             with each word and flags a sticky error on read mismatch.
//  Revision : 1.0  initial release
// ============================================================================
module mb_chbuf
   import mb_slice_pkg::*;
#(
   parameter int SLICE_W = 12,
   parameter int CHB_AW  = 7
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               adr_ld,
   input  wire logic [CHB_AW-1:0]  adr_in,
   input  wire logic               step,
   input  wire logic               reverse,
   input  wire logic               wr,
   input  wire logic [SLICE_W-1:0] wr_data,
   output      logic [CHB_AW-1:0]  adr,
   output      logic [SLICE_W-1:0] rd_data
`ifdef MB_CHB_PAR_EN
   , output    logic               par_err
`endif
);
   localparam int NGRP = SLICE_W / PAR_GRP;
`ifdef MB_CHB_PAR_EN
   localparam int ENT_W = SLICE_W + NGRP;
`else
   localparam int ENT_W = SLICE_W;
`endif

   logic [CHB_AW-1:0] r_adr;
   logic [ENT_W-1:0]  r_ram [2**CHB_AW];
   logic [ENT_W-1:0]  r_rd;
   logic [ENT_W-1:0]  w_wr_ent;

`ifdef MB_CHB_PAR_EN
   // Parity is stored inverted so an all-zero entry (and the cleared read
   // register) is self-consistent and never raises a false error.
   logic [NGRP-1:0] w_wr_par;
   logic [NGRP-1:0] w_rd_par;
   logic            r_par_err;

   for (genvar g = 0; g < NGRP; g++) begin : g_par
      assign w_wr_par[g] = odd_par6(wr_data[g*PAR_GRP +: PAR_GRP]);
      assign w_rd_par[g] = odd_par6(r_rd[g*PAR_GRP +: PAR_GRP]);
   end

   assign w_wr_ent = {~w_wr_par, wr_data};

   // Sticky parity error, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         r_par_err <= 1'b0;
      else if (r_rd[ENT_W-1:SLICE_W] != ~w_rd_par)
         r_par_err <= 1'b1;
   end

   assign par_err = r_par_err;
`else
   assign w_wr_ent = wr_data;
`endif

   // Address counter: load beats step; steps wrap naturally at the counter width
   always_ff @(posedge clk) begin
      if (rst)
         r_adr <= '0;
      else if (adr_ld)
         r_adr <= adr_in;
      else if (step)
         r_adr <= reverse ? r_adr - 1'b1 : r_adr + 1'b1;
   end

   // RAM write at the pre-step address; suppressed during reset, contents never cleared
   always_ff @(posedge clk) begin
      if (!rst && wr)
         r_ram[r_adr] <= w_wr_ent;
   end

   // Registered read every cycle; same-address write returns the old word
   always_ff @(posedge clk) begin
      if (rst)
         r_rd <= '0;
      else
         r_rd <= r_ram[r_adr];
   end

   assign adr     = r_adr;
   assign rd_data = r_rd[SLICE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mb_slice_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mb_slice_gen
//  Brief    : Parametrised MB data-path slice: MB source mux, odd parity per
//             6-bit group, held memory words, CCW buffer, channel buffer and
//             registered CBUS transmit. Optional macro: MB_CHB_PAR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mb_slice_gen
   import mb_slice_pkg::*;
#(
   parameter int SLICE_W = 12,
   parameter int WORDS   = 4,
   parameter int CHB_AW  = 7,
   parameter int CCW_AW  = 4
) (
   input wire logic     clk_mb_h,
   input wire logic     mr_reset_h,
   mb_slice_gen_if.slave bus
);
   localparam int NGRP = SLICE_W / PAR_GRP;

   logic [SLICE_W-1:0] r_mb;
   logic [SLICE_W-1:0] r_word [WORDS];
   logic [SLICE_W-1:0] r_ccw [2**CCW_AW];
   logic [SLICE_W-1:0] r_cbus_te;
   logic [SLICE_W-1:0] w_mb_next;
   logic [SLICE_W-1:0] w_ccw_mix;
   logic [SLICE_W-1:0] w_m2c;
   logic [SLICE_W-1:0] w_chb_rd;
   logic [CHB_AW-1:0]  w_chb_adr;

   // MB source multiplexer
   always_comb begin
      w_mb_next = r_mb;
      case (mb_src_e'(bus.mb_in_sel_h))
         MB_SRC_AR:      w_mb_next = bus.ar_h;
         MB_SRC_CACHE:   w_mb_next = bus.cache_data_h;
         MB_SRC_MEM:     w_mb_next = bus.mem_data_in_h;
         MB_SRC_CHB:     w_mb_next = w_chb_rd;
         MB_SRC_CCW_MIX: w_mb_next = w_ccw_mix;
         MB_SRC_CBUS:    w_mb_next = bus.cbus_re_h;
         MB_SRC_WORD:    w_mb_next = r_word[bus.mb_word_sel_h];
         default:        w_mb_next = r_mb;
      endcase
   end

   // MB register
   always_ff @(posedge clk_mb_h) begin
      if (mr_reset_h)
         r_mb <= '0;
      else if (!bus.mb_sel_hold_h)
         r_mb <= w_mb_next;
   end

   // Held memory words: every unheld word captures the strobed memory data
   for (genvar k = 0; k < WORDS; k++) begin : g_word
      always_ff @(posedge clk_mb_h) begin
         if (mr_reset_h)
            r_word[k] <= '0;
         else if (bus.mem_data_ld_h && !bus.mb_hold_in_h[k])
            r_word[k] <= bus.mem_data_in_h;
      end
   end

   // CCW buffer write port (contents not reset)
   always_ff @(posedge clk_mb_h) begin
      if (bus.ccw_buf_wr_h)
         r_ccw[bus.ccw_buf_adr_h] <= bus.ccw_buf_in_h;
   end

   // CCW mix: MB or combinational CCW buffer read
   always_comb begin
      w_ccw_mix = bus.ccl_mix_mb_sel_h ? r_mb : r_ccw[bus.ccw_buf_adr_h];
   end

   // CBUS transmit register follows the channel-buffer read unless frozen
   always_ff @(posedge clk_mb_h) begin
      if (mr_reset_h)
         r_cbus_te <= '0;
      else if (!bus.cbus_out_hold_h)
         r_cbus_te <= w_chb_rd;
   end

   // Cache write data source, forced to zero when disabled
   always_comb begin
      w_m2c = '0;
      if (bus.mem_to_c_en_h) begin
         case (m2c_src_e'(bus.mem_to_c_sel_h))
            M2C_SRC_MEM:  w_m2c = bus.mem_data_in_h;
            M2C_SRC_MB:   w_m2c = r_mb;
            M2C_SRC_AR:   w_m2c = bus.ar_h;
            M2C_SRC_CBUS: w_m2c = bus.cbus_re_h;
            default:      w_m2c = '0;
         endcase
      end
   end

   for (genvar g = 0; g < NGRP; g++) begin : g_par
      assign bus.mb_par_odd_h[g] = odd_par6(r_mb[g*PAR_GRP +: PAR_GRP]);
   end

   mb_chbuf #(
      .SLICE_W (SLICE_W),
      .CHB_AW  (CHB_AW)
   ) u_chbuf (
      .clk     (clk_mb_h),
      .rst     (mr_reset_h),
      .adr_ld  (bus.chb_adr_ld_h),
      .adr_in  (bus.chb_adr_in_h),
      .step    (bus.chb_step_h),
      .reverse (bus.ch_reverse_h),
      .wr      (bus.chb_wr_h),
      .wr_data (r_mb),
      .adr     (w_chb_adr),
      .rd_data (w_chb_rd)
`ifdef MB_CHB_PAR_EN
      , .par_err (bus.chb_par_err_h)
`endif
   );

   assign bus.mb_h           = r_mb;
   assign bus.ccw_mix_h      = w_ccw_mix;
   assign bus.mem_to_cache_h = w_m2c;
   assign bus.pt_in_h        = bus.mem_to_c_en_h ? w_m2c : bus.cache_data_h;
   assign bus.cbus_te_h      = r_cbus_te;
   assign bus.chb_adr_h      = w_chb_adr;

endmodule
`default_nettype wire

// File: tb/tb_mb_slice_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mb_slice_gen
//  Brief    : Self-checking bench for mb_slice_gen: directed scenarios then
//             randomized traffic against a cycle-level behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mb_slice_gen;

   localparam int SW  = 12;
   localparam int NW  = 4;
   localparam int CAW = 7;
   localparam int QAW = 4;
   localparam int CHB_N = 2**CAW;
   localparam int CCW_N = 2**QAW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mb_slice_gen_if #(.SLICE_W(SW), .WORDS(NW), .CHB_AW(CAW), .CCW_AW(QAW)) bus ();

   mb_slice_gen #(.SLICE_W(SW), .WORDS(NW), .CHB_AW(CAW), .CCW_AW(QAW)) dut (
      .clk_mb_h   (clk),
      .mr_reset_h (rst),
      .bus        (bus)
   );

   // ---------------- reference model state ----------------
   logic [SW-1:0] m_mb, m_te, m_rd;
   bit            m_mb_v, m_te_v, m_rd_v;
   logic [SW-1:0] m_word [NW];
   int            m_adr;
   logic [SW-1:0] m_chb [CHB_N];
   bit            m_chb_v [CHB_N];
   logic [SW-1:0] m_ccw [CCW_N];
   bit            m_ccw_v [CCW_N];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o expected %0o (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_par(input logic [SW-1:0] v);
      logic [1:0] p;
      for (int g = 0; g < 2; g++)
         p[g] = ($countones(v[g*6 +: 6]) % 2) == 0;
      return p;
   endfunction

   // Advance the model by one clock using the inputs present at the edge
   task automatic model_update();
      logic [SW-1:0] n_mb, mix, n_rd;
      bit            n_mb_v, mix_v, n_rd_v;
      if (rst) begin
         m_mb = '0; m_mb_v = 1; m_te = '0; m_te_v = 1; m_rd = '0; m_rd_v = 1;
         m_adr = 0;
         for (int k = 0; k < NW; k++) m_word[k] = '0;
      end else begin
         n_rd   = m_chb[m_adr];
         n_rd_v = m_chb_v[m_adr];
         mix    = bus.ccl_mix_mb_sel_h ? m_mb : m_ccw[bus.ccw_buf_adr_h];
         mix_v  = bus.ccl_mix_mb_sel_h ? m_mb_v : m_ccw_v[bus.ccw_buf_adr_h];
         n_mb = m_mb; n_mb_v = m_mb_v;
         if (!bus.mb_sel_hold_h) begin
            case (bus.mb_in_sel_h)
               3'd0: begin n_mb = bus.ar_h;          n_mb_v = 1; end
               3'd1: begin n_mb = bus.cache_data_h;  n_mb_v = 1; end
               3'd2: begin n_mb = bus.mem_data_in_h; n_mb_v = 1; end
               3'd3: begin n_mb = m_rd;              n_mb_v = m_rd_v; end
               3'd4: begin n_mb = mix;               n_mb_v = mix_v; end
               3'd5: begin n_mb = bus.cbus_re_h;     n_mb_v = 1; end
               3'd6: begin n_mb = m_word[bus.mb_word_sel_h]; n_mb_v = 1; end
               default: ;
            endcase
         end
         if (bus.chb_wr_h) begin
            m_chb[m_adr]   = m_mb;
            m_chb_v[m_adr] = m_mb_v;
         end
         if (!bus.cbus_out_hold_h) begin
            m_te = m_rd; m_te_v = m_rd_v;
         end
         m_rd = n_rd; m_rd_v = n_rd_v;
         for (int k = 0; k < NW; k++)
            if (bus.mem_data_ld_h && !bus.mb_hold_in_h[k]) m_word[k] = bus.mem_data_in_h;
         if (bus.chb_adr_ld_h)
            m_adr = int'(bus.chb_adr_in_h);
         else if (bus.chb_step_h)
            m_adr = (m_adr + (bus.ch_reverse_h ? CHB_N - 1 : 1)) % CHB_N;
         m_mb = n_mb; m_mb_v = n_mb_v;
      end
      if (bus.ccw_buf_wr_h) begin
         m_ccw[bus.ccw_buf_adr_h]   = bus.ccw_buf_in_h;
         m_ccw_v[bus.ccw_buf_adr_h] = 1;
      end
   endtask

   // Compare every observable output with the model
   task automatic check_outputs();
      logic [SW-1:0] e_m2c;
      bit            e_m2c_v;
      if (m_mb_v) begin
         chk("mb", bus.mb_h, m_mb);
         chk("parity", bus.mb_par_odd_h, exp_par(m_mb));
      end
      chk("chb_adr", bus.chb_adr_h, m_adr);
      if (m_te_v) chk("cbus_te", bus.cbus_te_h, m_te);
      if (bus.ccl_mix_mb_sel_h) begin
         if (m_mb_v) chk("ccw_mix_mb", bus.ccw_mix_h, m_mb);
      end else if (m_ccw_v[bus.ccw_buf_adr_h]) begin
         chk("ccw_mix_buf", bus.ccw_mix_h, m_ccw[bus.ccw_buf_adr_h]);
      end
      e_m2c = '0; e_m2c_v = 1;
      if (bus.mem_to_c_en_h) begin
         case (bus.mem_to_c_sel_h)
            2'd0: e_m2c = bus.mem_data_in_h;
            2'd1: begin e_m2c = m_mb; e_m2c_v = m_mb_v; end
            2'd2: e_m2c = bus.ar_h;
            default: e_m2c = bus.cbus_re_h;
         endcase
      end
      if (e_m2c_v) begin
         chk("mem_to_cache", bus.mem_to_cache_h, e_m2c);
         chk("pt_in", bus.pt_in_h, bus.mem_to_c_en_h ? e_m2c : bus.cache_data_h);
      end
`ifdef MB_CHB_PAR_EN
      chk("chb_par_err", bus.chb_par_err_h, 1'b0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check_outputs();
   endtask

   task automatic idle_inputs();
      bus.ar_h = '0; bus.cache_data_h = '0; bus.mem_data_in_h = '0;
      bus.ccw_buf_in_h = '0; bus.cbus_re_h = '0;
      bus.mb_in_sel_h = 3'd7; bus.mb_sel_hold_h = 1'b0; bus.mb_word_sel_h = '0;
      bus.mem_data_ld_h = 1'b0; bus.mb_hold_in_h = '0;
      bus.chb_adr_ld_h = 1'b0; bus.chb_adr_in_h = '0; bus.chb_step_h = 1'b0;
      bus.ch_reverse_h = 1'b0; bus.chb_wr_h = 1'b0;
      bus.ccw_buf_wr_h = 1'b0; bus.ccw_buf_adr_h = '0; bus.ccl_mix_mb_sel_h = 1'b1;
      bus.mem_to_c_en_h = 1'b0; bus.mem_to_c_sel_h = '0; bus.cbus_out_hold_h = 1'b0;
   endtask

   localparam logic [SW-1:0] VA = 12'o1234;
   localparam logic [SW-1:0] VB = 12'o4321;
   localparam logic [SW-1:0] VC = 12'o5555;

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_mb", bus.mb_h, 12'o0000);
      chk("rst_par", bus.mb_par_odd_h, 2'b11);
      chk("rst_te", bus.cbus_te_h, 12'o0000);
      chk("rst_adr", bus.chb_adr_h, 7'd0);

      // AR into MB
      bus.ar_h = 12'o0001; bus.mb_in_sel_h = 3'd0;
      tick();
      chk("ar_mb", bus.mb_h, 12'o0001);
      chk("ar_par", bus.mb_par_odd_h, 2'b10);
      bus.mb_in_sel_h = 3'd7;

      // Held words with per-word hold
      bus.mem_data_in_h = 12'o7777; bus.mem_data_ld_h = 1'b1; bus.mb_hold_in_h = 4'b0101;
      tick();
      bus.mem_data_ld_h = 1'b0; bus.mem_data_in_h = '0;
      for (int w = 0; w < NW; w++) begin
         bus.mb_in_sel_h = 3'd6; bus.mb_word_sel_h = 2'(w);
         tick();
         chk($sformatf("word%0d", w), bus.mb_h, (w % 2) ? 12'o7777 : 12'o0000);
      end

      // Forward writes wrapping past the top, then reverse read-back
      bus.chb_adr_ld_h = 1'b1; bus.chb_adr_in_h = 7'd126;
      bus.mb_in_sel_h = 3'd0; bus.ar_h = VA;
      tick();
      chk("ld126", bus.chb_adr_h, 7'd126);
      bus.chb_adr_ld_h = 1'b0; bus.chb_wr_h = 1'b1; bus.chb_step_h = 1'b1;
      bus.ar_h = VB; tick();
      bus.ar_h = VC; tick();
      bus.mb_in_sel_h = 3'd7; tick();
      chk("wrap_adr", bus.chb_adr_h, 7'd1);
      bus.chb_wr_h = 1'b0; bus.chb_step_h = 1'b0;
      bus.chb_adr_ld_h = 1'b1; bus.chb_adr_in_h = 7'd0;
      tick();
      bus.chb_adr_ld_h = 1'b0; bus.ch_reverse_h = 1'b1; bus.chb_step_h = 1'b1;
      tick();
      chk("rev_adr", bus.chb_adr_h, 7'd127);
      tick();
      chk("rev_te_c", bus.cbus_te_h, VC);
      tick();
      chk("rev_te_b", bus.cbus_te_h, VB);
      bus.chb_step_h = 1'b0;
      tick();
      chk("rev_te_a", bus.cbus_te_h, VA);

      // CBUS transmit hold
      bus.cbus_out_hold_h = 1'b1;
      bus.chb_adr_ld_h = 1'b1; bus.chb_adr_in_h = 7'd127;
      tick();
      bus.chb_adr_ld_h = 1'b0;
      tick();
      chk("te_hold", bus.cbus_te_h, VA);
      bus.cbus_out_hold_h = 1'b0;
      tick();
      chk("te_release", bus.cbus_te_h, VB);

      // mem_to_cache / pt_in
      bus.mem_to_c_en_h = 1'b0; bus.cache_data_h = 12'o3456; bus.ar_h = 12'o2525;
      #1;
      chk("m2c_off", bus.mem_to_cache_h, 12'o0000);
      chk("pt_off", bus.pt_in_h, 12'o3456);
      bus.mem_to_c_en_h = 1'b1; bus.mem_to_c_sel_h = 2'd2;
      #1;
      chk("m2c_ar", bus.mem_to_cache_h, 12'o2525);
      chk("pt_ar", bus.pt_in_h, 12'o2525);
      tick();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst                   = ($urandom_range(0, 99) == 0);
         bus.ar_h              = SW'($urandom);
         bus.cache_data_h      = SW'($urandom);
         bus.mem_data_in_h     = SW'($urandom);
         bus.ccw_buf_in_h      = SW'($urandom);
         bus.cbus_re_h         = SW'($urandom);
         bus.mb_in_sel_h       = 3'($urandom);
         bus.mb_sel_hold_h     = ($urandom_range(0, 7) == 0);
         bus.mb_word_sel_h     = 2'($urandom);
         bus.mem_data_ld_h     = 1'($urandom);
         bus.mb_hold_in_h      = 4'($urandom);
         bus.chb_adr_ld_h      = ($urandom_range(0, 15) == 0);
         bus.chb_adr_in_h      = ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom);
         bus.chb_step_h        = ($urandom_range(0, 3) != 0);
         bus.ch_reverse_h      = 1'($urandom);
         bus.chb_wr_h          = 1'($urandom);
         bus.ccw_buf_wr_h      = 1'($urandom);
         bus.ccw_buf_adr_h     = 4'($urandom);
         bus.ccl_mix_mb_sel_h  = 1'($urandom);
         bus.mem_to_c_en_h     = 1'($urandom);
         bus.mem_to_c_sel_h    = 2'($urandom);
         bus.cbus_out_hold_h   = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
